// File: rtl/axi_lite_dmem_bridge.sv
// AXI4-Lite slave bridging the PS onto data-memory Port B: one transaction in
// flight, registered Port B strobes, read-modify-write for partial strobes.
module axi_lite_dmem_bridge #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic              we_b,
  output logic [31:0]       addr_b,
  output logic [31:0]       din_b,
  input  logic [31:0]       dout_b
);

  localparam int unsigned WW = ADDR_W - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [3:0] {
    IDLE, WR_FULL, RMW_RD, RMW_WAIT, RMW_WR, WR_RESP,
    RD_ISSUE, RD_WAIT, RD_RESP, ERR_RESP
  } state_t;

  state_t state, state_n;

  logic          aw_full, aw_full_n, w_full, w_full_n, ar_full, ar_full_n;
  logic [WW-1:0] aw_word, ar_word;
  logic [31:0]   w_data;
  logic [3:0]    w_strb;
  logic          last_grant_rd, last_grant_rd_n;
  logic          wr_release, rd_release;
  logic          grant_wr, grant_rd;
  logic          we_b_n, bvalid_n, rvalid_n;
  logic [31:0]   addr_b_n, din_b_n, rdata_n, merged;
  logic [1:0]    bresp_n, rresp_n;

  logic unused_addr_lsbs;
  assign unused_addr_lsbs = &{1'b0, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  function automatic logic in_range(input logic [WW-1:0] word);
    return 34'(word) < 34'(MEM_WORDS);
  endfunction

  // READY mirrors the next-cycle "holding register empty" so it is registered.
  assign aw_full_n = wr_release ? 1'b0 : (aw_full | (s_axi_awvalid & s_axi_awready));
  assign w_full_n  = wr_release ? 1'b0 : (w_full  | (s_axi_wvalid  & s_axi_wready));
  assign ar_full_n = rd_release ? 1'b0 : (ar_full | (s_axi_arvalid & s_axi_arready));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_full       <= 1'b0;
      w_full        <= 1'b0;
      ar_full       <= 1'b0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_arready <= 1'b0;
      aw_word       <= '0;
      ar_word       <= '0;
      w_data        <= '0;
      w_strb        <= '0;
    end else begin
      aw_full       <= aw_full_n;
      w_full        <= w_full_n;
      ar_full       <= ar_full_n;
      s_axi_awready <= !aw_full_n;
      s_axi_wready  <= !w_full_n;
      s_axi_arready <= !ar_full_n;
      if (s_axi_awvalid && s_axi_awready) aw_word <= s_axi_awaddr[ADDR_W-1:2];
      if (s_axi_arvalid && s_axi_arready) ar_word <= s_axi_araddr[ADDR_W-1:2];
      if (s_axi_wvalid && s_axi_wready) begin
        w_data <= s_axi_wdata;
        w_strb <= s_axi_wstrb;
      end
    end
  end

  always_comb begin
    merged = '0;
    for (int unsigned i = 0; i < 4; i++)
      merged[8*i +: 8] = w_strb[i] ? w_data[8*i +: 8] : dout_b[8*i +: 8];
  end

  assign grant_wr = aw_full && w_full && (!ar_full || last_grant_rd);
  assign grant_rd = ar_full && !grant_wr;

  always_comb begin
    state_n         = state;
    last_grant_rd_n = last_grant_rd;
    wr_release      = 1'b0;
    rd_release      = 1'b0;
    we_b_n          = 1'b0;
    addr_b_n        = addr_b;
    din_b_n         = din_b;
    rdata_n         = s_axi_rdata;
    bvalid_n        = s_axi_bvalid;
    rvalid_n        = s_axi_rvalid;
    bresp_n         = s_axi_bresp;
    rresp_n         = s_axi_rresp;
    case (state)
      IDLE: begin
        if (grant_wr) begin
          last_grant_rd_n = 1'b0;
          if (!in_range(aw_word)) begin
            state_n  = ERR_RESP;
            bvalid_n = 1'b1;
            bresp_n  = RESP_SLVERR;
          end else if (w_strb == 4'hF) begin
            state_n  = WR_FULL;
            we_b_n   = 1'b1;
            addr_b_n = 32'({aw_word, 2'b00});
            din_b_n  = w_data;
          end else if (w_strb == 4'h0) begin
            state_n  = WR_RESP;
            bvalid_n = 1'b1;
            bresp_n  = RESP_OKAY;
          end else begin
            state_n  = RMW_RD;
            addr_b_n = 32'({aw_word, 2'b00});
          end
        end else if (grant_rd) begin
          last_grant_rd_n = 1'b1;
          if (!in_range(ar_word)) begin
            state_n  = ERR_RESP;
            rvalid_n = 1'b1;
            rresp_n  = RESP_SLVERR;
            rdata_n  = '0;
          end else begin
            state_n  = RD_ISSUE;
            addr_b_n = 32'({ar_word, 2'b00});
          end
        end
      end
      RMW_RD:   state_n = RMW_WAIT;
      RMW_WAIT: begin
        state_n = RMW_WR;
        we_b_n  = 1'b1;
        din_b_n = merged;
      end
      WR_FULL, RMW_WR: begin
        state_n  = WR_RESP;
        bvalid_n = 1'b1;
        bresp_n  = RESP_OKAY;
      end
      WR_RESP: begin
        if (s_axi_bready) begin
          state_n    = IDLE;
          bvalid_n   = 1'b0;
          wr_release = 1'b1;
        end
      end
      RD_ISSUE: state_n = RD_WAIT;
      RD_WAIT: begin
        state_n  = RD_RESP;
        rvalid_n = 1'b1;
        rresp_n  = RESP_OKAY;
        rdata_n  = dout_b;
      end
      RD_RESP: begin
        if (s_axi_rready) begin
          state_n    = IDLE;
          rvalid_n   = 1'b0;
          rd_release = 1'b1;
        end
      end
      ERR_RESP: begin
        if (s_axi_bvalid && s_axi_bready) begin
          state_n    = IDLE;
          bvalid_n   = 1'b0;
          wr_release = 1'b1;
        end else if (s_axi_rvalid && s_axi_rready) begin
          state_n    = IDLE;
          rvalid_n   = 1'b0;
          rd_release = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      last_grant_rd <= 1'b1;
      we_b          <= 1'b0;
      addr_b        <= '0;
      din_b         <= '0;
      s_axi_rdata   <= '0;
      s_axi_bvalid  <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_bresp   <= '0;
      s_axi_rresp   <= '0;
    end else begin
      state         <= state_n;
      last_grant_rd <= last_grant_rd_n;
      we_b          <= we_b_n;
      addr_b        <= addr_b_n;
      din_b         <= din_b_n;
      s_axi_rdata   <= rdata_n;
      s_axi_bvalid  <= bvalid_n;
      s_axi_rvalid  <= rvalid_n;
      s_axi_bresp   <= bresp_n;
      s_axi_rresp   <= rresp_n;
    end
  end

endmodule

// File: tb/tb_axi_lite_dmem_bridge.sv
// Directed bench for axi_lite_dmem_bridge with a behavioural Port B memory.
module tb_axi_lite_dmem_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] s_axi_awaddr = '0, s_axi_araddr = '0;
  logic        s_axi_awvalid = 1'b0, s_axi_wvalid = 1'b0, s_axi_arvalid = 1'b0;
  logic        s_axi_bready = 1'b0, s_axi_rready = 1'b0;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic [31:0] s_axi_rdata, addr_b, din_b;
  logic        we_b;
  logic [31:0] dout_b = '0;

  always #5 clk = ~clk;

  axi_lite_dmem_bridge #(.ADDR_W(16), .MEM_WORDS(1024)) dut (
    .clk(clk), .rst(rst_n),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b)
  );

  // Synchronous-read memory: dout_b valid one edge after addr_b.
  logic [31:0] mem [1024];
  always @(posedge clk) begin
    dout_b <= mem[addr_b[11:2]];
    if (we_b) mem[addr_b[11:2]] <= din_b;
  end

  int unsigned checks = 0, fails = 0;
  int          cyc = 0;
  int          we_cnt = 0;
  logic [31:0] we_addr = '0;
  logic        log_en = 1'b0;
  int          ev_n = 0;
  logic [1:0]  ev_kind [6];
  logic [31:0] ev_data [6];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (we_b) begin
      we_cnt  <= we_cnt + 1;
      we_addr <= addr_b;
    end
    if (log_en && ev_n < 6) begin
      if (s_axi_bvalid && s_axi_bready) begin
        ev_kind[ev_n] <= 2'd1;
        ev_data[ev_n] <= '0;
        ev_n          <= ev_n + 1;
      end else if (s_axi_rvalid && s_axi_rready) begin
        ev_kind[ev_n] <= 2'd2;
        ev_data[ev_n] <= s_axi_rdata;
        ev_n          <= ev_n + 1;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish within limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic send_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                            output int e0);
    logic aw_done, w_done, aw_hs, w_hs;
    aw_done = 1'b0; w_done = 1'b0; e0 = -100;
    @(negedge clk);
    s_axi_awaddr = a; s_axi_awvalid = 1'b1;
    s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
    for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      @(negedge clk);
      if (aw_hs) begin s_axi_awvalid = 1'b0; aw_done = 1'b1; end
      if (w_hs)  begin s_axi_wvalid  = 1'b0; w_done  = 1'b1; end
      if (aw_done && w_done) e0 = cyc;
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    chk("aw_w_accepted", {30'd0, aw_done, w_done}, 32'd3);
  endtask

  task automatic send_read(input logic [15:0] a, output int e0);
    logic done, hs;
    done = 1'b0; e0 = -100;
    @(negedge clk);
    s_axi_araddr = a; s_axi_arvalid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      hs = s_axi_arvalid && s_axi_arready;
      @(negedge clk);
      if (hs) begin s_axi_arvalid = 1'b0; done = 1'b1; e0 = cyc; end
    end
    s_axi_arvalid = 1'b0;
    chk("ar_accepted", {31'd0, done}, 32'd1);
  endtask

  task automatic wait_b(input string tag, input int e0, input int lat, input logic [1:0] resp);
    for (int i = 0; i < 50 && !s_axi_bvalid; i++) @(negedge clk);
    chk({tag, "_bvalid"}, {31'd0, s_axi_bvalid}, 32'd1);
    chk({tag, "_blatency"}, cyc - e0, lat);
    chk({tag, "_bresp"}, {30'd0, s_axi_bresp}, {30'd0, resp});
    s_axi_bready = 1'b1;
    @(negedge clk);
    s_axi_bready = 1'b0;
    chk({tag, "_bvalid_clear"}, {31'd0, s_axi_bvalid}, 32'd0);
  endtask

  task automatic wait_r(input string tag, input int e0, input int lat, input logic [1:0] resp,
                        input logic [31:0] data);
    for (int i = 0; i < 50 && !s_axi_rvalid; i++) @(negedge clk);
    chk({tag, "_rvalid"}, {31'd0, s_axi_rvalid}, 32'd1);
    chk({tag, "_rlatency"}, cyc - e0, lat);
    chk({tag, "_rresp"}, {30'd0, s_axi_rresp}, {30'd0, resp});
    chk({tag, "_rdata"}, s_axi_rdata, data);
    s_axi_rready = 1'b1;
    @(negedge clk);
    s_axi_rready = 1'b0;
    chk({tag, "_rvalid_clear"}, {31'd0, s_axi_rvalid}, 32'd0);
  endtask

  task automatic contend(input string tag, input logic [15:0] wa, input logic [31:0] wd,
                         input logic [15:0] ra);
    int base;
    base = ev_n;
    @(negedge clk);
    chk({tag, "_ready"}, {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd7);
    s_axi_awaddr = wa; s_axi_wdata = wd; s_axi_wstrb = 4'hF; s_axi_araddr = ra;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
    @(negedge clk);
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    for (int i = 0; i < 50 && ev_n < base + 2; i++) @(negedge clk);
    @(negedge clk);
    chk({tag, "_events"}, ev_n - base, 2);
  endtask

  int e0, we_before;
  logic [15:0] tmp_a;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_readies", {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd0);
    chk("rst_valids", {30'd0, s_axi_bvalid, s_axi_rvalid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_readies", {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd7);
    chk("post_rst_we_b", {31'd0, we_b}, 32'd0);
    chk("post_rst_addr_b", addr_b, 32'd0);
    chk("post_rst_din_b", din_b, 32'd0);
    chk("post_rst_rdata", s_axi_rdata, 32'd0);
    chk("post_rst_resps", {28'd0, s_axi_bresp, s_axi_rresp}, 32'd0);

    // Full write then read back
    we_before = we_cnt;
    send_write(16'h0040, 32'hDEADBEEF, 4'hF, e0);
    wait_b("full_wr", e0, 2, 2'b00);
    chk("full_wr_we_pulses", we_cnt - we_before, 1);
    chk("full_wr_addr_b", we_addr, 32'h0000_0040);
    send_read(16'h0040, e0);
    wait_r("full_rd", e0, 3, 2'b00, 32'hDEADBEEF);

    // Partial strobe read-modify-write
    send_write(16'h0010, 32'h11223344, 4'hF, e0);
    wait_b("pre_rmw", e0, 2, 2'b00);
    we_before = we_cnt;
    send_write(16'h0010, 32'hAABBCCDD, 4'b0101, e0);
    wait_b("rmw_wr", e0, 4, 2'b00);
    chk("rmw_we_pulses", we_cnt - we_before, 1);
    send_read(16'h0010, e0);
    wait_r("rmw_rd", e0, 3, 2'b00, 32'h11BB33DD);

    // Zero strobe: OKAY with no Port B write
    we_before = we_cnt;
    send_write(16'h0010, 32'h0, 4'h0, e0);
    wait_b("zero_strb", e0, 1, 2'b00);
    chk("zero_strb_no_we", we_cnt - we_before, 0);

    // Out-of-range accesses
    we_before = we_cnt;
    send_read(16'h1000, e0);
    wait_r("oor_rd", e0, 1, 2'b10, 32'h0);
    send_write(16'h2000, 32'h5A5A5A5A, 4'hF, e0);
    wait_b("oor_wr", e0, 1, 2'b10);
    chk("oor_no_we", we_cnt - we_before, 0);

    // W early, AW late, bready held low
    @(negedge clk);
    s_axi_wdata = 32'h12345678; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    @(negedge clk);
    s_axi_wvalid = 1'b0;
    chk("early_w_wready_low", {31'd0, s_axi_wready}, 32'd0);
    repeat (2) @(negedge clk);
    chk("early_w_wready_held", {31'd0, s_axi_wready}, 32'd0);
    s_axi_awaddr = 16'h0080; s_axi_awvalid = 1'b1;
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    chk("late_aw_awready_low", {31'd0, s_axi_awready}, 32'd0);
    @(negedge clk);
    chk("late_aw_b_not_early", {31'd0, s_axi_bvalid}, 32'd0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("stall_bvalid", {31'd0, s_axi_bvalid}, 32'd1);
      chk("stall_bresp", {30'd0, s_axi_bresp}, 32'd0);
      chk("stall_wready", {31'd0, s_axi_wready}, 32'd0);
      @(negedge clk);
    end
    s_axi_bready = 1'b1;
    @(negedge clk);
    s_axi_bready = 1'b0;
    chk("stall_bvalid_clear", {31'd0, s_axi_bvalid}, 32'd0);
    chk("stall_wready_back", {31'd0, s_axi_wready}, 32'd1);
    send_read(16'h0080, e0);
    wait_r("stall_rd", e0, 3, 2'b00, 32'h12345678);

    // Contention: round-robin between write and read
    s_axi_bready = 1'b1; s_axi_rready = 1'b1; log_en = 1'b1;
    contend("contend1", 16'h00C0, 32'hCAFEF00D, 16'h0040);
    contend("contend2", 16'h00C4, 32'h00000001, 16'h00C0);
    log_en = 1'b0; s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    send_write(16'h00C8, 32'h0BADF00D, 4'hF, e0);
    wait_b("solo_wr", e0, 2, 2'b00);
    s_axi_bready = 1'b1; s_axi_rready = 1'b1; log_en = 1'b1;
    contend("contend3", 16'h00CC, 32'h00000002, 16'h00C8);
    log_en = 1'b0; s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    chk("grant0", {30'd0, ev_kind[0]}, 32'd1);
    chk("grant1", {30'd0, ev_kind[1]}, 32'd2);
    chk("grant2", {30'd0, ev_kind[2]}, 32'd1);
    chk("grant3", {30'd0, ev_kind[3]}, 32'd2);
    chk("grant4_read_first", {30'd0, ev_kind[4]}, 32'd2);
    chk("grant5", {30'd0, ev_kind[5]}, 32'd1);
    chk("contend1_rdata", ev_data[1], 32'hDEADBEEF);
    chk("contend2_rdata", ev_data[3], 32'hCAFEF00D);
    chk("contend3_rdata", ev_data[4], 32'h0BADF00D);

    // Reset asserted while the RMW waits on read data
    send_write(16'h0100, 32'h55667788, 4'hF, e0);
    wait_b("pre_rst_wr", e0, 2, 2'b00);
    send_write(16'h0100, 32'hFFFFFFFF, 4'b0011, e0);
    repeat (2) @(negedge clk);
    we_before = we_cnt;
    rst_n = 1'b0;
    #1;
    chk("midrst_readies", {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd0);
    chk("midrst_valids", {30'd0, s_axi_bvalid, s_axi_rvalid}, 32'd0);
    chk("midrst_we_b", {31'd0, we_b}, 32'd0);
    chk("midrst_addr_b", addr_b, 32'd0);
    chk("midrst_din_b", din_b, 32'd0);
    chk("midrst_rdata", s_axi_rdata, 32'd0);
    chk("midrst_resps", {28'd0, s_axi_bresp, s_axi_rresp}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst_no_we", we_cnt - we_before, 0);
    chk("midrst_no_bvalid", {31'd0, s_axi_bvalid}, 32'd0);
    send_read(16'h0100, e0);
    wait_r("post_rst_rd", e0, 3, 2'b00, 32'h55667788);
    tmp_a = 16'h0104;
    send_write(tmp_a, 32'h87654321, 4'hF, e0);
    wait_b("post_rst_wr", e0, 2, 2'b00);
    send_read(tmp_a, e0);
    wait_r("post_rst_rd2", e0, 3, 2'b00, 32'h87654321);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  logic unused_tb;
  assign unused_tb = &{1'b0, addr_b[31:12], addr_b[1:0]};

endmodule
